// File: rtl/stage4_msg_batch_module.sv
// Byte-serial message assembler for the stage-5 field extractors: builds up to
// three message words, classifies them by type byte, and emits them as one batch.
`timescale 1ns/1ps

`ifndef MAX_MESSAGE_BITS
`define MAX_MESSAGE_BITS 128
`endif
`ifndef MESSAGE_MUX_CONTROL_WIDTH
`define MESSAGE_MUX_CONTROL_WIDTH 4
`endif
`ifndef MESSAGE_MUX_Q
`define MESSAGE_MUX_Q 4'h1
`endif

module stage4_msg_batch_module #(
  parameter int                MSG_BITS     = `MAX_MESSAGE_BITS,
  parameter int                CTRL_W       = `MESSAGE_MUX_CONTROL_WIDTH,
  parameter logic [CTRL_W-1:0] CTRL_Q       = `MESSAGE_MUX_Q,
  parameter logic [CTRL_W-1:0] CTRL_NONE    = '0,
  parameter logic [7:0]        TYPE_Q       = 8'h51,
  parameter int                FLUSH_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic                message_en,
  output logic [MSG_BITS-1:0] message_1,
  output logic [MSG_BITS-1:0] message_2,
  output logic [MSG_BITS-1:0] message_3,
  output logic [CTRL_W-1:0]   message_mux_control_m1,
  output logic [CTRL_W-1:0]   message_mux_control_m2,
  output logic [CTRL_W-1:0]   message_mux_control_m3,
  output logic                err_pulse
);

  localparam int MAX_BYTES = MSG_BITS / 8;
  localparam int BC_W      = $clog2(MAX_BYTES + 1);
  localparam int FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [BC_W-1:0] MAX_CNT    = BC_W'(MAX_BYTES);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BODY,
    S_DROP
  } state_t;

  state_t              state;
  logic [BC_W-1:0]     byte_cnt;
  logic [MSG_BITS-1:0] asm_word;
  logic [FC_W-1:0]     flush_cnt;
  logic [1:0]          slot_cnt;
  logic [MSG_BITS-1:0] slot_word [2];
  logic [CTRL_W-1:0]   slot_ctrl [2];

  int                  wr_idx;
  logic [MSG_BITS-1:0] start_word;
  logic [MSG_BITS-1:0] body_word;
  logic [MSG_BITS-1:0] done_word;
  logic [CTRL_W-1:0]   done_ctrl;
  logic                start;
  logic                abort;
  logic                overflow;
  logic                done;
  logic                full_emit;
  logic                flush_emit;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_idx = 0;
    if (byte_cnt < MAX_CNT) wr_idx = int'(byte_cnt);

    start_word = '0;
    start_word[MSG_BITS-1 -: 8] = in_data;
    body_word = asm_word;
    body_word[MSG_BITS-1-8*wr_idx -: 8] = in_data;

    start    = in_valid && in_sop;
    abort    = start && (state == S_BODY);
    overflow = in_valid && !in_sop && (state == S_BODY) && (byte_cnt >= MAX_CNT);
    done     = in_valid && in_eop && (start || ((state == S_BODY) && !overflow));

    done_word = start ? start_word : body_word;
    done_ctrl = (done_word[MSG_BITS-1 -: 8] == TYPE_Q) ? CTRL_Q : CTRL_NONE;

    full_emit  = done && (slot_cnt == 2'd2);
    flush_emit = !in_valid && (state == S_IDLE) && (slot_cnt != 2'd0) &&
                 (flush_cnt == FLUSH_LAST);
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      byte_cnt               <= '0;
      asm_word               <= '0;
      flush_cnt              <= '0;
      slot_cnt               <= '0;
      message_en             <= 1'b0;
      err_pulse              <= 1'b0;
      message_1              <= '0;
      message_2              <= '0;
      message_3              <= '0;
      message_mux_control_m1 <= CTRL_NONE;
      message_mux_control_m2 <= CTRL_NONE;
      message_mux_control_m3 <= CTRL_NONE;
      // NOTE: the slot registers are reset, not left as uninitialised storage,
      // because a flush copies unfilled slots straight out as zero words.
      for (int i = 0; i < 2; i++) begin
        slot_word[i] <= '0;
        slot_ctrl[i] <= CTRL_NONE;
      end
    end else begin
      message_en <= 1'b0;
      err_pulse  <= abort || overflow;

      // Assembly: sop restarts from any state; otherwise behaviour depends on state.
      if (in_valid) begin
        if (in_sop) begin
          asm_word <= start_word;
          byte_cnt <= BC_W'(1);
          state    <= in_eop ? S_IDLE : S_BODY;
        end else begin
          case (state)
            S_BODY: begin
              if (overflow) begin
                state <= in_eop ? S_IDLE : S_DROP;
              end else begin
                asm_word <= body_word;
                byte_cnt <= byte_cnt + 1'b1;
                if (in_eop) state <= S_IDLE;
              end
            end
            S_DROP:  if (in_eop) state <= S_IDLE;
            default: ;
          endcase
        end
      end

      if (in_valid || (state != S_IDLE) || (slot_cnt == 2'd0) || flush_emit)
        flush_cnt <= '0;
      else
        flush_cnt <= flush_cnt + 1'b1;

      // The third message goes straight to the outputs; it never occupies a slot.
      if (full_emit || flush_emit) begin
        message_en             <= 1'b1;
        message_1              <= slot_word[0];
        message_2              <= slot_word[1];
        message_mux_control_m1 <= slot_ctrl[0];
        message_mux_control_m2 <= slot_ctrl[1];
        message_3              <= full_emit ? done_word : '0;
        message_mux_control_m3 <= full_emit ? done_ctrl : CTRL_NONE;
        slot_cnt               <= '0;
        for (int i = 0; i < 2; i++) begin
          slot_word[i] <= '0;
          slot_ctrl[i] <= CTRL_NONE;
        end
      end else if (done) begin
        slot_word[slot_cnt[0]] <= done_word;
        slot_ctrl[slot_cnt[0]] <= done_ctrl;
        slot_cnt               <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage4_msg_batch_module.sv
// Self-checking bench for stage4_msg_batch_module: a byte-queue reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps

module tb_stage4_msg_batch_module;

  localparam int         MSG_BITS  = 128;
  localparam int         MAX_BYTES = MSG_BITS / 8;
  localparam int         CTRL_W    = 4;
  localparam logic [3:0] C_Q       = 4'h1;
  localparam logic [3:0] C_NONE    = 4'h0;
  localparam logic [7:0] T_Q       = 8'h51;
  localparam int         FLUSH     = 16;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_sop;
  logic                in_eop;
  logic                message_en;
  logic [MSG_BITS-1:0] message_1, message_2, message_3;
  logic [CTRL_W-1:0]   ctrl_1, ctrl_2, ctrl_3;
  logic                err_pulse;

  stage4_msg_batch_module #(
    .MSG_BITS(MSG_BITS), .CTRL_W(CTRL_W), .CTRL_Q(C_Q), .CTRL_NONE(C_NONE),
    .TYPE_Q(T_Q), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .message_en(message_en),
    .message_1(message_1), .message_2(message_2), .message_3(message_3),
    .message_mux_control_m1(ctrl_1), .message_mux_control_m2(ctrl_2),
    .message_mux_control_m3(ctrl_3), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                en;
    logic                err;
    logic [MSG_BITS-1:0] m [3];
    logic [CTRL_W-1:0]   c [3];
  } exp_t;

  exp_t exp_cur, exp_nxt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_total = 0, err_total = 0, last_en_cyc = -1, last_err_cyc = -1;
  logic prev_en = 1'b0;
  logic hold_rst;

  // Reference model state: the message being received as a byte list, plus the
  // list of completed messages waiting for a batch.
  logic [7:0]          mb [$];
  int                  mode;      // 0 waiting for sop, 1 receiving, 2 discarding
  logic [MSG_BITS-1:0] pw [$];
  logic [CTRL_W-1:0]   pc [$];
  int                  idle_cnt;

  task automatic check(input string name, input logic [MSG_BITS-1:0] act,
                       input logic [MSG_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mb.delete(); pw.delete(); pc.delete();
    mode = 0; idle_cnt = 0;
    exp_nxt.en = 1'b0; exp_nxt.err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_nxt.m[i] = '0;
      exp_nxt.c[i] = C_NONE;
    end
  endtask

  task automatic model_emit();
    for (int i = 0; i < 3; i++) begin
      exp_nxt.m[i] = (i < pw.size()) ? pw[i] : '0;
      exp_nxt.c[i] = (i < pc.size()) ? pc[i] : C_NONE;
    end
    pw.delete(); pc.delete();
    exp_nxt.en = 1'b1;
    idle_cnt = 0;
  endtask

  task automatic model_finish();
    logic [MSG_BITS-1:0] w;
    w = '0;
    foreach (mb[k]) w[MSG_BITS-1-8*k -: 8] = mb[k];
    pw.push_back(w);
    pc.push_back((mb[0] == T_Q) ? C_Q : C_NONE);
    mb.delete();
    mode = 0;
    if (pw.size() == 3) model_emit();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic s,
                            input logic e);
    exp_nxt.en = 1'b0;
    exp_nxt.err = 1'b0;
    if (v) begin
      idle_cnt = 0;
      if (s) begin
        if (mode == 1) exp_nxt.err = 1'b1;
        mb.delete(); mb.push_back(d); mode = 1;
        if (e) model_finish();
      end else if (mode == 1) begin
        if (mb.size() >= MAX_BYTES) begin
          exp_nxt.err = 1'b1;
          mb.delete();
          mode = e ? 0 : 2;
        end else begin
          mb.push_back(d);
          if (e) model_finish();
        end
      end else if (mode == 2 && e) begin
        mode = 0;
      end
    end else if (mode == 0 && pw.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == FLUSH) model_emit();
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and advances the model.
  task automatic step(input logic v, input logic [7:0] d, input logic s, input logic e);
    @(posedge clk); #1;
    rst_n = !hold_rst;
    in_valid = v; in_data = d; in_sop = s; in_eop = e;
    cyc++;
    if (!rst_n) begin
      model_reset();
      exp_cur = exp_nxt;
    end else begin
      exp_cur = exp_nxt;
      model_step(v, d, s, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Message of len bytes: type byte, then base+1, base+2, ...
  task automatic send(input logic [7:0] typ, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++)
      step(1'b1, (k == 0) ? typ : base + 8'(k), k == 0, k == len - 1);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  always @(negedge clk) begin
    check("message_en", {127'd0, message_en}, {127'd0, exp_cur.en});
    check("err_pulse", {127'd0, err_pulse}, {127'd0, exp_cur.err});
    check("message_1", message_1, exp_cur.m[0]);
    check("message_2", message_2, exp_cur.m[1]);
    check("message_3", message_3, exp_cur.m[2]);
    check("ctrl_m1", {124'd0, ctrl_1}, {124'd0, exp_cur.c[0]});
    check("ctrl_m2", {124'd0, ctrl_2}, {124'd0, exp_cur.c[1]});
    check("ctrl_m3", {124'd0, ctrl_3}, {124'd0, exp_cur.c[2]});
    if (prev_en) check("en_spacing", {127'd0, message_en}, '0);
    prev_en = message_en;
    if (message_en) begin en_total++; last_en_cyc = cyc; end
    if (err_pulse) begin err_total++; last_err_cyc = cyc; end
  end

  int en0, err0, c0;

  initial begin
    hold_rst = 1'b1;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    model_reset();
    exp_cur = exp_nxt;
    idle(3);
    settle();
    check("rst_en", {127'd0, message_en}, '0);
    check("rst_m1", message_1, '0);
    check("rst_c3", {124'd0, ctrl_3}, {124'd0, C_NONE});
    hold_rst = 1'b0;
    idle(2);

    // Full batch: types Q, A, Q.
    en0 = en_total;
    send(8'h51, 4, 8'h10);
    send(8'h41, 4, 8'h20);
    send(8'h51, 4, 8'h30);
    c0 = cyc;
    idle(1);
    settle();
    check("batch_latency", 128'(last_en_cyc - c0), 128'd1);
    check("batch_m1_top", {96'd0, message_1[127 -: 32]}, {96'd0, 32'h51111213});
    check("batch_m1_low", {32'd0, message_1[95:0]}, '0);
    check("batch_m2_top", {96'd0, message_2[127 -: 32]}, {96'd0, 32'h41212223});
    check("batch_m3_top", {96'd0, message_3[127 -: 32]}, {96'd0, 32'h51313233});
    check("batch_ctrl1", {124'd0, ctrl_1}, 128'h1);
    check("batch_ctrl2", {124'd0, ctrl_2}, 128'h0);
    check("batch_ctrl3", {124'd0, ctrl_3}, 128'h1);
    idle(3);
    check("batch_en_once", 128'(en_total - en0), 128'd1);

    // Flush of a single one-byte Q message.
    en0 = en_total;
    send(8'h51, 1, 8'h00);
    c0 = cyc;
    idle(17);
    settle();
    check("flush_latency", 128'(last_en_cyc - c0), 128'd17);
    check("flush_count", 128'(en_total - en0), 128'd1);
    check("flush_m1", message_1, {8'h51, 120'd0});
    check("flush_m2", message_2, '0);
    check("flush_m3", message_3, '0);
    check("flush_ctrl1", {124'd0, ctrl_1}, 128'h1);
    check("flush_ctrl2", {124'd0, ctrl_2}, 128'h0);
    idle(2);

    // Traffic in the cycle that would expire the counter cancels the flush.
    en0 = en_total;
    send(8'h51, 1, 8'h00);
    c0 = cyc;
    idle(15);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(1);
    settle();
    check("cancel_no_en", 128'(en_total - en0), 128'd0);
    idle(20);
    check("cancel_late_en", 128'(last_en_cyc - c0), 128'd33);

    // Abort: new sop in the middle of a message.
    en0 = en_total; err0 = err_total;
    step(1'b1, 8'h41, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h51, 1'b1, 1'b0);
    c0 = cyc;
    step(1'b1, 8'h77, 1'b0, 1'b1);
    idle(17);
    settle();
    check("abort_err_cnt", 128'(err_total - err0), 128'd1);
    check("abort_err_lat", 128'(last_err_cyc - c0), 128'd1);
    check("abort_m1", message_1, {16'h5177, 112'd0});
    check("abort_en", 128'(en_total - en0), 128'd1);

    // Overflow: MAX_BYTES+3 bytes, then a valid two-byte Q message.
    en0 = en_total; err0 = err_total;
    step(1'b1, 8'h41, 1'b1, 1'b0);
    for (int i = 1; i < MAX_BYTES + 2; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    send(8'h51, 2, 8'h90);
    idle(17);
    settle();
    check("ovf_err_cnt", 128'(err_total - err0), 128'd1);
    check("ovf_m1", message_1, {16'h5191, 112'd0});
    check("ovf_en", 128'(en_total - en0), 128'd1);

    // Back-to-back: seven one-byte messages on consecutive cycles.
    en0 = en_total;
    c0 = cyc;
    for (int i = 0; i < 7; i++) step(1'b1, 8'h60 + 8'(i), 1'b1, 1'b1);
    settle();
    check("b2b_en_two", 128'(en_total - en0), 128'd2);
    check("b2b_last_en", 128'(last_en_cyc - c0), 128'd7);
    check("b2b_m1", message_1, {8'h63, 120'd0});
    check("b2b_m3", message_3, {8'h65, 120'd0});
    idle(17);
    settle();
    check("b2b_en_three", 128'(en_total - en0), 128'd3);
    check("b2b_m1_flush", message_1, {8'h66, 120'd0});

    // Reset with two slots filled and a message mid-body.
    send(8'h51, 2, 8'h10);
    send(8'h41, 1, 8'h00);
    step(1'b1, 8'h42, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    hold_rst = 1'b1;
    idle(1);
    settle();
    check("mid_rst_m1", message_1, '0);
    check("mid_rst_ctrl1", {124'd0, ctrl_1}, {124'd0, C_NONE});
    idle(2);
    hold_rst = 1'b0;
    en0 = en_total;
    idle(30);
    check("mid_rst_no_en", 128'(en_total - en0), 128'd0);

    // Random traffic, including stray sop/eop while in_valid is low.
    for (int n = 0; n < 2500; n++) begin
      logic v, s, e;
      int eop_div;
      if ($urandom_range(96) == 0) begin
        idle(20);
      end else begin
        eop_div = ((n / 200) % 2 == 1) ? 24 : 4;
        v = ($urandom_range(3) != 0);
        s = ($urandom_range(7) == 0);
        e = ($urandom_range(eop_div - 1) == 0);
        step(v, ($urandom_range(3) == 0) ? T_Q : 8'($urandom), s, e);
      end
    end
    idle(20);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
